div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the MIPS DIV/DIVU path.
- Sits in the EX stage, directly upstream of the HI/LO register file.
- Takes 32-bit dividend and divisor and produces quotient (to LO) and remainder (to HI).
- Holds the pipeline via `stall` while iterating; emits a one-cycle `done` that drives the HI/LO divide write-enable.

---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Divider request/result bundle between EX control and div_unit.
// The master drives the request; the slave (div_unit) returns results.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;

  modport master (
    output start, signed_div, annul,
    output dividend, divisor,
    input  stall, done, hi_res, lo_res
  );

  modport slave (
    input  start, signed_div, annul,
    input  dividend, divisor,
    output stall, done, hi_res, lo_res
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to LO, remainder to HI; stalls EX while iterating.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    FIN
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_stall;
  logic             r_done;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic             w_last;

  // Magnitudes of the incoming operands; unsigned ops pass through.
  assign w_neg_a = bus.signed_div & bus.dividend[WIDTH-1];
  assign w_neg_b = bus.signed_div & bus.divisor[WIDTH-1];
  assign w_abs_a = w_neg_a ? -bus.dividend : bus.dividend;
  assign w_abs_b = w_neg_b ? -bus.divisor : bus.divisor;

  // One restoring step: shift next dividend bit into the partial remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_rem_n = w_ge ? (w_shift[WIDTH-1:0] - r_dvs)
                        : w_shift[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};
  assign w_last  = r_cnt == CW'(WIDTH - 1);

  assign bus.stall  = r_stall;
  assign bus.done   = r_done;
  assign bus.hi_res = r_hi;
  assign bus.lo_res = r_lo;

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_stall <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start && !bus.annul) begin
            if (bus.divisor == '0) begin
              r_lo    <= '1;
              r_hi    <= bus.dividend;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_qneg  <= w_neg_a ^ w_neg_b;
              r_rneg  <= w_neg_a;
              r_cnt   <= '0;
              r_stall <= 1'b1;
              r_state <= ON;
            end
          end
        end
        ON: begin
          if (bus.annul) begin
            r_stall <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_lo    <= r_qneg ? -w_quo_n : w_quo_n;
              r_hi    <= r_rneg ? -w_rem_n : w_rem_n;
              r_stall <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_stall <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Results are checked against a 64-bit arithmetic reference model.
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division; remainder follows dividend sign.
  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic [31:0] q,
    output logic [31:0] r
  );
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0];
    r = lr[31:0];
  endfunction

  // Issue one divide from IDLE (called at #1 after an edge) and check it.
  // poke >= 0 pulses a bogus start with new operands at that cycle.
  task automatic run_div(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sgn,
    input int          poke,
    input string       name
  );
    int n;
    int elat;
    model(a, b, sgn, exp_lo, exp_hi);
    elat = (b == 32'd0) ? 0 : 32;
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      checks++;
      if (bus.stall !== 1'b1) begin
        failures++;
        $display("FAIL %s stall n=%0d got=%b want=1", name, n, bus.stall);
      end
      bus.start = (n == poke);
      if (n == poke) begin
        bus.signed_div = $urandom;
        bus.dividend   = $urandom;
        bus.divisor    = $urandom | 32'd1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n !== elat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, n, elat);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL %s stall_at_done got=%b want=0", name, bus.stall);
    end
    checks++;
    if (bus.lo_res !== exp_lo) begin
      failures++;
      $display("FAIL %s lo got=%h want=%h", name, bus.lo_res, exp_lo);
    end
    checks++;
    if (bus.hi_res !== exp_hi) begin
      failures++;
      $display("FAIL %s hi got=%h want=%h", name, bus.hi_res, exp_hi);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse got=%b want=0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul      = 1'b0;
    bus.dividend   = 32'd0;
    bus.divisor    = 32'd0;
    rst = 1'b1;
    #12;
    checks++;
    if ({bus.stall, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00", {bus.stall, bus.done});
    end
    checks++;
    if ({bus.hi_res, bus.lo_res} !== 64'd0) begin
      failures++;
      $display("FAIL reset_res got=%h want=0", {bus.hi_res, bus.lo_res});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, -1, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, -1, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "div_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1, "divu_max_1");
    run_div(32'd5, 32'd0, 1'b0, -1, "divu_by_zero");
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, -1, "div_by_zero");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = b >> $urandom_range(31, 16);
      if (i % 8 == 7) b = 32'd0;
      run_div(a, b, i[0], -1, "random");
    end
  endtask

  task automatic test_ignore_start();
    run_div(32'd1000, 32'd33, 1'b0, 5, "start_in_on");
    run_div(32'hFFFF_FC18, 32'd33, 1'b1, 31, "start_late_on");
  endtask

  task automatic test_annul();
    int seen;
    logic [31:0] keep_hi, keep_lo;
    keep_hi = exp_hi;
    keep_lo = exp_lo;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd12345;
    bus.divisor    = 32'd17;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    checks++;
    if ({bus.stall, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL annul_on_flags got=%b want=00", {bus.stall, bus.done});
    end
    seen = 0;
    repeat (40) begin
      if (bus.done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL annul_no_done got=%0d want=0", seen);
    end
    checks++;
    if ({bus.hi_res, bus.lo_res} !== {keep_hi, keep_lo}) begin
      failures++;
      $display("FAIL annul_keep got=%h want=%h",
               {bus.hi_res, bus.lo_res}, {keep_hi, keep_lo});
    end
    bus.start    = 1'b1;
    bus.dividend = 32'd123;
    bus.divisor  = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.annul = 1'b1;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL annul_fin_done got=%b want=0", bus.done);
    end
    checks++;
    if ({bus.hi_res, bus.lo_res} !== {32'd123, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL annul_fin_keep got=%h want=%h",
               {bus.hi_res, bus.lo_res}, {32'd123, 32'hFFFF_FFFF});
    end
    run_div(32'd77, 32'd8, 1'b0, -1, "after_annul");
  endtask

  task automatic test_rst_mid();
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd99999;
    bus.divisor    = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_flags got=%b want=00", {bus.stall, bus.done});
    end
    checks++;
    if ({bus.hi_res, bus.lo_res} !== 64'd0) begin
      failures++;
      $display("FAIL rst_mid_res got=%h want=0", {bus.hi_res, bus.lo_res});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(32'd9, 32'd3, 1'b0, -1, "after_rst");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_annul();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
